// File: rtl/psum_deskew_collector.sv
// psum_deskew_collector: re-aligns skewed systolic-array column outputs into row vectors and buffers them in a valid/ready FIFO
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear of delay lines, FIFO, row counter and overflow flag
//   in_valid    : column-0 partial sum of a row is on psum_flat this cycle
//   psum_flat   : array output, column j at [j*PSW +: PSW], column j lags column 0 by j cycles
//   out_valid   : aligned row at FIFO head
//   out_ready   : consumer accepts the head row
//   out_data    : aligned row, same column packing as psum_flat
//   out_last    : head row is the last row (index SIZE-1) of its tile
//   fifo_count  : rows currently buffered
//   overflow    : sticky, an aligned row arrived while the FIFO was full and was dropped
module psum_deskew_collector #(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int ACTIVATION_WIDTH  = 8,
    parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       flush,
    input  logic                                       in_valid,
    input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] psum_flat,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] out_data,
    output logic                                       out_last,
    output logic [$clog2(FIFO_DEPTH):0]                fifo_count,
    output logic                                       overflow
);
    localparam int N   = SYSTOLIC_SIZE;
    localparam int PSW = PARTIAL_SUM_WIDTH;
    localparam int FW  = N * PSW;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int RW  = $clog2(N);

    logic [FW-1:0] aligned;

    // Column j waits N-1-j cycles so every column of a row lands together
    // in the cycle its delayed valid reaches the end of the valid chain.
    for (genvar j = 0; j < N; j++) begin : g_col
        if (j == N - 1) begin : g_direct
            assign aligned[j*PSW +: PSW] = psum_flat[j*PSW +: PSW];
        end else begin : g_dl
            localparam int L = N - 1 - j;
            logic [PSW-1:0] sh_q [L];
            logic [PSW-1:0] sh_d [L];
            always_comb begin
                sh_d[0] = flush ? '0 : psum_flat[j*PSW +: PSW];
                for (int k = 1; k < L; k++) sh_d[k] = flush ? '0 : sh_q[k-1];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < L; k++) sh_q[k] <= '0;
                end else begin
                    for (int k = 0; k < L; k++) sh_q[k] <= sh_d[k];
                end
            end
            assign aligned[j*PSW +: PSW] = sh_q[L-1];
        end
    end

    logic [N-2:0]    vld_q, vld_d;
    logic [FW:0]     mem_q [FIFO_DEPTH];
    logic [FW:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [RW-1:0]   rowcnt_q, rowcnt_d;
    logic            ovf_q, ovf_d;
    logic            wr, pop, full, push, row_last;

    assign wr       = vld_q[N-2];
    assign pop      = (count_q != '0) && out_ready;
    assign full     = count_q == CW'(FIFO_DEPTH);
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign push     = wr && (!full || pop);
    assign row_last = rowcnt_q == RW'(N - 1);

    always_comb begin
        vld_d[0] = in_valid;
        for (int k = 1; k < N - 1; k++) vld_d[k] = vld_q[k-1];
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = {row_last, aligned};
        wptr_d   = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d   = pop ? rptr_q + AW'(1) : rptr_q;
        count_d  = (push && !pop) ? count_q + CW'(1) : (!push && pop) ? count_q - CW'(1) : count_q;
        rowcnt_d = push ? (row_last ? '0 : rowcnt_q + RW'(1)) : rowcnt_q;
        ovf_d    = ovf_q || (wr && full && !pop);
        if (flush) begin
            vld_d    = '0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem_d[k] = '0;
            wptr_d   = '0;
            rptr_d   = '0;
            count_d  = '0;
            rowcnt_d = '0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rowcnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= mem_d[k];
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rowcnt_q <= rowcnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid             = count_q != '0;
    assign {out_last, out_data}  = mem_q[rptr_q];
    assign fifo_count            = count_q;
    assign overflow              = ovf_q;
endmodule

// File: tb/tb_psum_deskew_collector.sv
// tb_psum_deskew_collector: directed bench for psum_deskew_collector (SIZE=8, DEPTH=4)
//   drives skewed rows where column j of row r carries 100+j+16*r, j cycles after in_valid
module tb_psum_deskew_collector;
    localparam int SIZE  = 8;
    localparam int PSW   = 19;
    localparam int DEPTH = 4;
    localparam int FW    = SIZE * PSW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [FW-1:0] psum_flat = '0;
    logic          out_valid;
    logic [FW-1:0] out_data;
    logic          out_last;
    logic [2:0]    fifo_count;
    logic          overflow;

    always #5 clk = ~clk;

    psum_deskew_collector #(
        .SYSTOLIC_SIZE(SIZE),
        .WEIGHT_WIDTH(8),
        .ACTIVATION_WIDTH(8),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_valid(in_valid),
        .psum_flat(psum_flat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    typedef struct {
        bit iv;
        int rid;
        bit rdy;
        bit fl;
        bit ev;
        int erid;
        bit el;
        int ecnt;
        bit eov;
    } vec_t;

    vec_t tv [28];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc_no = 0;
    int   hist [SIZE];

    function automatic logic [FW-1:0] row_of(int r);
        logic [FW-1:0] v;
        for (int j = 0; j < SIZE; j++) v[j*PSW +: PSW] = PSW'(100 + j + 16 * r);
        return v;
    endfunction

    task automatic chk(string n, logic [FW-1:0] a, logic [FW-1:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", n, cyc_no, a, e);
        end
    endtask

    // Applies one cycle of stimulus, checks the registered outputs of this cycle, advances to the next.
    task automatic cyc(bit iv, int rid, bit rdy, bit fl, bit ev, int erid, bit el, int ecnt, bit eov);
        in_valid  = iv;
        out_ready = rdy;
        flush     = fl;
        for (int j = SIZE - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = iv ? rid : -1;
        for (int j = 0; j < SIZE; j++)
            psum_flat[j*PSW +: PSW] = (hist[j] >= 0) ? PSW'(100 + j + 16 * hist[j]) : '0;
        chk("out_valid", FW'(out_valid), FW'(ev));
        chk("fifo_count", FW'(fifo_count), FW'(ecnt));
        chk("overflow", FW'(overflow), FW'(eov));
        if (ev) begin
            chk("out_data", out_data, row_of(erid));
            chk("out_last", FW'(out_last), FW'(el));
        end
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    initial begin
        for (int c = 0; c < 28; c++) tv[c] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[0].iv = 1;
        tv[8]    = '{0, 0, 1, 0, 1, 0, 0, 1, 0};
        tv[9]    = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
        for (int c = 10; c < 28; c++) begin
            tv[c].rdy = 1;
            tv[c].iv  = (c <= 18);
            tv[c].rid = c - 9;
            tv[c].ev  = (c >= 18 && c <= 26);
            tv[c].erid = c - 17;
            tv[c].el  = (c == 25);
            tv[c].ecnt = tv[c].ev ? 1 : 0;
        end
        for (int j = 0; j < SIZE; j++) hist[j] = -1;

        #3;
        chk("rst_out_valid", FW'(out_valid), FW'(0));
        chk("rst_fifo_count", FW'(fifo_count), FW'(0));
        chk("rst_overflow", FW'(overflow), FW'(0));
        chk("rst_out_last", FW'(out_last), FW'(0));
        chk("rst_out_data", out_data, '0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single row latency, then a tile of 8 rows plus one wrapping row
        for (int c = 0; c < 28; c++)
            cyc(tv[c].iv, tv[c].rid, tv[c].rdy, tv[c].fl, tv[c].ev, tv[c].erid, tv[c].el, tv[c].ecnt, tv[c].eov);

        // overflow: 6 rows into a 4-deep FIFO with the consumer stalled
        for (int c = 0; c < 14; c++) begin
            int cnt;
            cnt = (c < 8) ? 0 : ((c - 7 > 4) ? 4 : c - 7);
            cyc(c < 6, 20 + c, 0, 0, cnt > 0, 20, 0, cnt, c >= 12);
        end
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0, 1, 20 + k, 0, 4 - k, 1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0, 0, 0, 0, 0, 1);

        // push into a full FIFO while the head pops
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 1);
        for (int c = 0; c < 12; c++) begin
            int cnt;
            cnt = (c < 8) ? 0 : c - 7;
            cyc(c < 5, 30 + c, c == 11, 0, cnt > 0, 30, 0, cnt, 0);
        end
        for (int c = 12; c < 16; c++) cyc(0, 0, 1, 0, 1, 31 + (c - 12), 0, 4 - (c - 12), 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);

        // flush with rows both in the delay lines and in the FIFO
        for (int c = 0; c < 9; c++) cyc(c < 5, 40 + c, 0, 0, c == 8, 40, 0, (c == 8) ? 1 : 0, 0);
        cyc(1, 45, 0, 1, 1, 40, 0, 2, 0);
        for (int c = 0; c < 12; c++) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);

        // asynchronous reset between edges, then fresh latency
        for (int c = 0; c < 9; c++) cyc(c < 2, 50 + c, 0, 0, c == 8, 50, 0, (c == 8) ? 1 : 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", FW'(out_valid), FW'(0));
        chk("arst_fifo_count", FW'(fifo_count), FW'(0));
        chk("arst_out_data", out_data, '0);
        chk("arst_out_last", FW'(out_last), FW'(0));
        #2 rst_n = 1'b1;
        for (int j = 0; j < SIZE; j++) hist[j] = -1;
        for (int c = 0; c < 8; c++) cyc(c == 0, 60, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 60, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
